// File: rtl/fizzle_pkg.sv
// Shared types and default constants for the fizzlefade write engine.
package fizzle_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    FADE,
    ZERO,
    DONE
  } state_t;

  // Taps x^15 + x^14 + 1 give a maximal-length sequence for a 15-bit register.
  localparam logic [14:0] DEF_LFSR_TAPS = 15'b110000000000000;
  localparam logic [14:0] DEF_LFSR_SEED = 15'd1;

endpackage

// File: rtl/lfsr_seq.sv
// Fibonacci LFSR: shifts left, feedback is the XOR of the tapped bits.
// A synchronous load returns the register to SEED and takes priority over en.
module lfsr_seq
  import fizzle_pkg::*;
#(
  parameter int             LEN  = 15,
  parameter logic [LEN-1:0] TAPS = LEN'(DEF_LFSR_TAPS),
  parameter logic [LEN-1:0] SEED = LEN'(DEF_LFSR_SEED)
) (
  input  logic           clk_sys,
  input  logic           rst_sys,
  input  logic           en,
  input  logic           load,
  output logic [LEN-1:0] state,
  output logic [LEN-1:0] state_nxt
);

  logic fb;

  assign fb        = ^(state & TAPS);
  assign state_nxt = {state[LEN-2:0], fb};

  // LFSR state register: reset/load to the seed, otherwise step when enabled.
  always_ff @(posedge clk_sys or negedge rst_sys) begin
    if (!rst_sys) begin
      state <= SEED;
    end else if (load) begin
      state <= SEED;
    end else if (en) begin
      state <= state_nxt;
    end
  end

endmodule

// File: rtl/fizzle_writer.sv
// Fizzlefade write engine: after a start and FADE_WAIT frames, writes a fixed
// colour to every framebuffer pixel once, in LFSR order, rate-limited to one
// write per FADE_RATE cycles. Address 0 (never produced by the LFSR) is last.
module fizzle_writer
  import fizzle_pkg::*;
#(
  parameter int                  FB_WIDTH  = 160,
  parameter int                  FB_HEIGHT = 120,
  parameter int                  FB_DATAW  = 4,
  parameter int                  LFSR_LEN  = 15,
  parameter logic [LFSR_LEN-1:0] LFSR_TAPS = LFSR_LEN'(DEF_LFSR_TAPS),
  parameter logic [LFSR_LEN-1:0] LFSR_SEED = LFSR_LEN'(DEF_LFSR_SEED),
  parameter int                  FADE_WAIT = 120,
  parameter int                  FADE_RATE = 2000,
  localparam int                 FB_PIXELS = FB_WIDTH * FB_HEIGHT,
  localparam int                 FB_ADDRW  = $clog2(FB_PIXELS)
) (
  input  logic                clk_sys,
  input  logic                rst_sys,
  input  logic                frame_sys,
  input  logic                start,
  input  logic [FB_DATAW-1:0] colr,
  output logic                busy,
  output logic                done,
  output logic                fb_we,
  output logic [FB_ADDRW-1:0] fb_addr_write,
  output logic [FB_DATAW-1:0] fb_colr_write
);

  // A zero-length wait still needs a 1-bit counter to keep the vector legal.
  localparam int WAIT_W = (FADE_WAIT > 0) ? $clog2(FADE_WAIT + 1) : 1;
  localparam int RATE_W = $clog2(FADE_RATE + 1);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((FADE_WAIT > 0) ? (FADE_WAIT - 1) : 0);
  localparam logic [RATE_W-1:0] RATE_LAST = RATE_W'(FADE_RATE - 1);

  if (LFSR_LEN < FB_ADDRW) begin : g_chk_lfsr_len
    $error("fizzle_writer: LFSR_LEN (%0d) must be >= FB_ADDRW (%0d)", LFSR_LEN, FB_ADDRW);
  end
  if (FADE_RATE < 1) begin : g_chk_rate
    $error("fizzle_writer: FADE_RATE must be >= 1");
  end

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   cnt_wait_q;
  logic [RATE_W-1:0]   cnt_rate_q;
  logic [FB_DATAW-1:0] colr_q;
  logic [LFSR_LEN-1:0] lfsr_q, lfsr_nxt;
  logic                lfsr_en, lfsr_load;
  logic                accept, in_range, rate_tick;
  logic                wr_vld_p0;
  logic [FB_ADDRW-1:0] wr_addr_p0;
  logic                fb_we_p1;
  logic [FB_ADDRW-1:0] fb_addr_p1;
  logic [FB_DATAW-1:0] fb_colr_p1;

  lfsr_seq #(
    .LEN  (LFSR_LEN),
    .TAPS (LFSR_TAPS),
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk_sys   (clk_sys),
    .rst_sys   (rst_sys),
    .en        (lfsr_en),
    .load      (lfsr_load),
    .state     (lfsr_q),
    .state_nxt (lfsr_nxt)
  );

  assign accept    = start && ((state_q == IDLE) || (state_q == DONE));
  assign rate_tick = (cnt_rate_q == RATE_LAST);
  // Zero-extended compare so FB_PIXELS == 2**LFSR_LEN cannot wrap to 0.
  assign in_range  = int'(lfsr_q) < FB_PIXELS;

  // FSM state register.
  always_ff @(posedge clk_sys or negedge rst_sys) begin
    if (!rst_sys) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and write decision; out-of-range LFSR values are skipped without
  // waiting for a rate tick, in-range ones wait for the tick and are written.
  always_comb begin
    state_d    = state_q;
    lfsr_en    = 1'b0;
    lfsr_load  = 1'b0;
    wr_vld_p0  = 1'b0;
    wr_addr_p0 = '0;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          lfsr_load = 1'b1;
          if (FADE_WAIT == 0) state_d = FADE;
          else                state_d = WAIT;
        end
      end
      WAIT: begin
        if (frame_sys && (cnt_wait_q == WAIT_LAST)) state_d = FADE;
      end
      FADE: begin
        if (!in_range) begin
          lfsr_en = 1'b1;
        end else if (rate_tick) begin
          lfsr_en    = 1'b1;
          wr_vld_p0  = 1'b1;
          wr_addr_p0 = lfsr_q[FB_ADDRW-1:0];
        end
        if (lfsr_en && (lfsr_nxt == LFSR_SEED)) state_d = ZERO;
      end
      ZERO: begin
        if (rate_tick) begin
          wr_vld_p0  = 1'b1;
          wr_addr_p0 = '0;
          state_d    = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame-wait and rate counters plus the colour latched on an accepted start.
  always_ff @(posedge clk_sys or negedge rst_sys) begin
    if (!rst_sys) begin
      cnt_wait_q <= '0;
      cnt_rate_q <= '0;
      colr_q     <= '0;
    end else if (accept) begin
      cnt_wait_q <= '0;
      cnt_rate_q <= '0;
      colr_q     <= colr;
    end else begin
      if ((state_q == WAIT) && frame_sys) cnt_wait_q <= cnt_wait_q + 1'b1;
      if ((state_q == FADE) || (state_q == ZERO)) begin
        if (wr_vld_p0)       cnt_rate_q <= '0;
        else if (!rate_tick) cnt_rate_q <= cnt_rate_q + 1'b1;
      end
    end
  end

  // ---- stage p0 -> p1: registered write port; address/data hold between writes.
  always_ff @(posedge clk_sys or negedge rst_sys) begin
    if (!rst_sys) begin
      fb_we_p1   <= 1'b0;
      fb_addr_p1 <= '0;
      fb_colr_p1 <= '0;
    end else begin
      fb_we_p1 <= wr_vld_p0;
      if (wr_vld_p0) begin
        fb_addr_p1 <= wr_addr_p0;
        fb_colr_p1 <= colr_q;
      end
    end
  end

  assign fb_we         = fb_we_p1;
  assign fb_addr_write = fb_addr_p1;
  assign fb_colr_write = fb_colr_p1;
  assign busy          = (state_q == WAIT) || (state_q == FADE) || (state_q == ZERO);
  assign done          = (state_q == DONE);

endmodule

// File: tb/tb_fizzle_writer.sv
// Bench for fizzle_writer: three configurations (small 4x3 with frame wait,
// full-size at rate 1 with no wait, small with a 1-frame wait), directed steps
// with randomized colours and frame gaps, checked against set-level rules.
module tb_fizzle_writer;

  typedef int iq_t[$];

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int unsigned cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  // Instance A: 4x3, 4-bit LFSR, 2-frame wait, rate 3
  logic       a_rst, a_frame, a_start, a_busy, a_done, a_we;
  logic [3:0] a_colr, a_addr, a_data;
  // Instance B: default 160x120, no wait, rate 1
  logic        b_rst, b_frame, b_start, b_busy, b_done, b_we;
  logic [3:0]  b_colr, b_data;
  logic [14:0] b_addr;
  // Instance C: 4x3, 4-bit LFSR, 1-frame wait, rate 4
  logic       c_rst, c_frame, c_start, c_busy, c_done, c_we;
  logic [3:0] c_colr, c_addr, c_data;

  fizzle_writer #(
    .FB_WIDTH(4), .FB_HEIGHT(3), .FB_DATAW(4), .LFSR_LEN(4),
    .LFSR_TAPS(4'b1100), .LFSR_SEED(4'd1), .FADE_WAIT(2), .FADE_RATE(3)
  ) u_a (
    .clk_sys(clk_sys), .rst_sys(a_rst), .frame_sys(a_frame), .start(a_start),
    .colr(a_colr), .busy(a_busy), .done(a_done), .fb_we(a_we),
    .fb_addr_write(a_addr), .fb_colr_write(a_data)
  );

  fizzle_writer #(
    .FADE_WAIT(0), .FADE_RATE(1)
  ) u_b (
    .clk_sys(clk_sys), .rst_sys(b_rst), .frame_sys(b_frame), .start(b_start),
    .colr(b_colr), .busy(b_busy), .done(b_done), .fb_we(b_we),
    .fb_addr_write(b_addr), .fb_colr_write(b_data)
  );

  fizzle_writer #(
    .FB_WIDTH(4), .FB_HEIGHT(3), .FB_DATAW(4), .LFSR_LEN(4),
    .LFSR_TAPS(4'b1100), .LFSR_SEED(4'd1), .FADE_WAIT(1), .FADE_RATE(4)
  ) u_c (
    .clk_sys(clk_sys), .rst_sys(c_rst), .frame_sys(c_frame), .start(c_start),
    .colr(c_colr), .busy(c_busy), .done(c_done), .fb_we(c_we),
    .fb_addr_write(c_addr), .fb_colr_write(c_data)
  );

  // Write logs: address, data and cycle of every fb_we pulse.
  iq_t a_wa, a_wd, a_wc, b_wa, b_wd, b_wc, c_wa, c_wd, c_wc;

  always @(negedge clk_sys) begin
    if (a_we === 1'b1) begin a_wa.push_back(int'(a_addr)); a_wd.push_back(int'(a_data)); a_wc.push_back(int'(cyc)); end
    if (b_we === 1'b1) begin b_wa.push_back(int'(b_addr)); b_wd.push_back(int'(b_data)); b_wc.push_back(int'(cyc)); end
    if (c_we === 1'b1) begin c_wa.push_back(int'(c_addr)); c_wd.push_back(int'(c_data)); c_wc.push_back(int'(cyc)); end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic nedge(input int n);
    repeat (n) @(negedge clk_sys);
    #1;
  endtask

  // Reference rules for one complete fade: npix writes covering 0..npix-1 once,
  // all data = colour, gaps >= rate, address 0 last.
  task automatic check_fade(input string tag, input iq_t wa, input iq_t wd, input iq_t wc,
                            input int npix, input int rate, input int colr);
    bit seen[];
    int bad_addr = 0;
    int dup      = 0;
    int bad_data = 0;
    int bad_gap  = 0;
    seen = new[npix];
    foreach (wa[i]) begin
      if (wa[i] < 0 || wa[i] >= npix) bad_addr++;
      else begin
        if (seen[wa[i]]) dup++;
        seen[wa[i]] = 1'b1;
      end
      if (wd[i] != colr) bad_data++;
      if (i > 0 && (wc[i] - wc[i-1]) < rate) bad_gap++;
    end
    chk({tag, "_count"}, wa.size(), npix);
    chk({tag, "_range"}, bad_addr, 0);
    chk({tag, "_dup"},   dup, 0);
    chk({tag, "_data"},  bad_data, 0);
    chk({tag, "_gap"},   bad_gap, 0);
    chk({tag, "_last0"}, (wa.size() > 0) ? wa[wa.size()-1] : -1, 0);
  endtask

  task automatic a_frame_pulse();
    @(negedge clk_sys); a_frame = 1'b1;
    @(negedge clk_sys); a_frame = 1'b0;
  endtask

  task automatic a_wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && a_done !== 1'b1; i++) nedge(1);
    chk({tag, "_done"}, a_done, 1);
    chk({tag, "_busy_low"}, a_busy, 0);
  endtask

  // Full fade on instance A: start, verify no write before the second frame, finish.
  task automatic a_run(input string tag, input logic [3:0] c);
    a_wa.delete(); a_wd.delete(); a_wc.delete();
    @(negedge clk_sys); a_start = 1'b1; a_colr = c;
    nedge(1); a_start = 1'b0; a_colr = 4'($urandom);
    chk({tag, "_done_clr"}, a_done, 0);
    chk({tag, "_busy_set"}, a_busy, 1);
    repeat ($urandom_range(3, 10)) @(negedge clk_sys);
    a_frame_pulse();
    nedge(8);
    chk({tag, "_no_write_1frame"}, a_wa.size(), 0);
    a_frame_pulse();
    a_wait_done(tag, 400);
  endtask

  iq_t        seq1;
  int         n, mism;
  logic [3:0] c1, c2, bc, cc;

  initial begin
    a_rst = 1'b0; a_frame = 1'b0; a_start = 1'b0; a_colr = '0;
    b_rst = 1'b0; b_frame = 1'b0; b_start = 1'b0; b_colr = '0;
    c_rst = 1'b0; c_frame = 1'b0; c_start = 1'b0; c_colr = '0;
    nedge(3);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_done", a_done, 0);
    chk("rst_a_we",   a_we, 0);
    chk("rst_a_addr", a_addr, 0);
    chk("rst_a_data", a_data, 0);
    chk("rst_b_we",   b_we, 0);
    chk("rst_c_busy", c_busy, 0);
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    nedge(2);

    // Basic 4x3 fade with colour 5
    a_run("t1", 4'd5);
    check_fade("t1", a_wa, a_wd, a_wc, 12, 3, 5);
    chk("t1_first_addr", (a_wa.size() > 0) ? a_wa[0] : -1, 1);
    chk("t1_hold_addr", a_addr, 0);
    chk("t1_hold_data", a_data, 5);
    seq1 = a_wa;

    // Reset after 5 writes abandons the fade; restart repeats the sequence
    a_wa.delete(); a_wd.delete(); a_wc.delete();
    c1 = 4'($urandom_range(1, 15));
    @(negedge clk_sys); a_start = 1'b1; a_colr = c1;
    @(negedge clk_sys); a_start = 1'b0;
    a_frame_pulse();
    repeat ($urandom_range(2, 6)) @(negedge clk_sys);
    a_frame_pulse();
    for (int i = 0; i < 300 && a_wa.size() < 5; i++) nedge(1);
    chk("t4_five_writes", a_wa.size(), 5);
    a_rst = 1'b0;
    #1;
    chk("t4_rst_we",   a_we, 0);
    chk("t4_rst_busy", a_busy, 0);
    chk("t4_rst_done", a_done, 0);
    @(negedge clk_sys); #1 a_rst = 1'b1;
    nedge(40);
    chk("t4_no_more_writes", a_wa.size(), 5);
    mism = 0;
    for (int i = 0; i < 5 && i < a_wa.size() && i < seq1.size(); i++)
      if (a_wa[i] != seq1[i]) mism++;
    chk("t4_partial_seq", mism, 0);
    c1 = 4'($urandom_range(1, 15));
    a_run("t4r", c1);
    check_fade("t4r", a_wa, a_wd, a_wc, 12, 3, int'(c1));
    mism = 0;
    for (int i = 0; i < a_wa.size() && i < seq1.size(); i++)
      if (a_wa[i] != seq1[i]) mism++;
    chk("t4_same_seq", mism, 0);

    // Start during FADE is ignored; start in DONE runs a new fade of colour 9
    a_wa.delete(); a_wd.delete(); a_wc.delete();
    c1 = 4'($urandom_range(1, 15));
    c2 = (c1 == 4'd15) ? 4'd1 : c1 + 4'd1;
    @(negedge clk_sys); a_start = 1'b1; a_colr = c1;
    @(negedge clk_sys); a_start = 1'b0;
    a_frame_pulse();
    a_frame_pulse();
    for (int i = 0; i < 300 && a_wa.size() < 3; i++) nedge(1);
    chk("t5_three_writes", a_wa.size(), 3);
    a_start = 1'b1; a_colr = c2;
    nedge(1); a_start = 1'b0;
    chk("t5_busy_kept", a_busy, 1);
    a_wait_done("t5", 400);
    check_fade("t5", a_wa, a_wd, a_wc, 12, 3, int'(c1));
    a_run("t5b", 4'd9);
    check_fade("t5b", a_wa, a_wd, a_wc, 12, 3, 9);

    // Full-size fade at rate 1 with no frame wait
    b_wa.delete(); b_wd.delete(); b_wc.delete();
    bc = 4'($urandom_range(1, 15));
    @(negedge clk_sys); b_start = 1'b1; b_colr = bc;
    @(posedge clk_sys); n = 1; #1 b_start = 1'b0;
    chk("t3_busy", b_busy, 1);
    while (b_we !== 1'b1 && n < 20) begin @(posedge clk_sys); n++; #1; end
    chk("t3_first_we_latency", n, 2);
    for (int i = 0; i < 40000 && b_done !== 1'b1; i++) nedge(1);
    chk("t2_done", b_done, 1);
    check_fade("t2", b_wa, b_wd, b_wc, 19200, 1, int'(bc));
    chk("t2_first_addr", (b_wa.size() > 0) ? b_wa[0] : -1, 1);

    // frame_sys coincident with start is not counted
    c_wa.delete(); c_wd.delete(); c_wc.delete();
    cc = 4'($urandom_range(1, 15));
    @(negedge clk_sys); c_start = 1'b1; c_frame = 1'b1; c_colr = cc;
    @(negedge clk_sys); c_start = 1'b0; c_frame = 1'b0;
    nedge(20);
    chk("t6_no_write", c_wa.size(), 0);
    chk("t6_busy", c_busy, 1);
    @(negedge clk_sys); c_frame = 1'b1;
    @(posedge clk_sys); n = 0; #1 c_frame = 1'b0;
    while (c_we !== 1'b1 && n < 50) begin @(posedge clk_sys); n++; #1; end
    chk("t6_first_we_after_frame", n, 4);
    for (int i = 0; i < 400 && c_done !== 1'b1; i++) nedge(1);
    chk("t6_done", c_done, 1);
    check_fade("t6", c_wa, c_wd, c_wc, 12, 4, int'(cc));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
